// File: rtl/matrix_alu_seq_if.sv
// Execution-engine bus bundle for the sequential matrix ALU.
interface matrix_alu_seq_if #(
    parameter int unsigned MW = 256
);
    logic [15:0]   address;
    logic          nRead;
    logic          nWrite;
    logic [MW-1:0] ExeDataOut;
    logic [MW-1:0] MatrixDataOut;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output address, nRead, nWrite, ExeDataOut,
        input  MatrixDataOut, busy, done, err
    );

    modport slave (
        input  address, nRead, nWrite, ExeDataOut,
        output MatrixDataOut, busy, done, err
    );
endinterface

// File: rtl/matrix_alu_seq.sv
// Sequential DIM x DIM matrix ALU: operands loaded by bus writes, element-serial
// execution under an IDLE/RUN/DONE FSM, result returned by a registered bus read.
module matrix_alu_seq #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DIM    = 4,
    parameter logic [3:0]  BASE   = 4'h2
) (
    input  logic             Clk,
    input  logic             nReset,
    matrix_alu_seq_if.slave  bus
);
    localparam int unsigned NE = DIM * DIM;
    localparam int unsigned MW = NE * DATA_W;
    localparam int unsigned CW = (DIM > 2) ? $clog2(DIM) : 1;
    localparam int unsigned IW = $clog2(NE);
    localparam logic [CW-1:0] LAST = CW'(DIM - 1);

    localparam logic [3:0] OP_MUL = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_TRN = 4'd3;
    localparam logic [3:0] OP_SCL = 4'd4;
    localparam logic [3:0] OP_SCI = 4'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              r_state;
    state_e              w_state_nxt;

    logic [DATA_W-1:0]   r_src1 [NE];
    logic [DATA_W-1:0]   r_src2 [NE];
    logic [DATA_W-1:0]   r_res  [NE];
    logic [DATA_W-1:0]   r_scalar;
    logic [DATA_W-1:0]   r_acc;
    logic [CW-1:0]       r_row;
    logic [CW-1:0]       r_col;
    logic [CW-1:0]       r_k;
    logic [3:0]          r_op;
    logic [MW-1:0]       r_mdo;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic                w_sel;
    logic                w_wr;
    logic                w_rd;
    logic                w_both;
    logic                w_any;
    logic                w_idle;
    logic                w_start;
    logic                w_legal;
    logic                w_start_ok;
    logic                w_err_set;
    logic                w_rd_ok;
    logic                w_last;
    logic                w_elem_wr;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic [DATA_W-1:0]   w_mac;
    logic [DATA_W-1:0]   w_elem;
    logic [MW-1:0]       w_res_packed;
    logic                w_unused;

    // Flat element index of [row][col].
    function automatic logic [IW-1:0] f_idx(input logic [CW-1:0] row, input logic [CW-1:0] col);
        return IW'(row) * IW'(DIM) + IW'(col);
    endfunction

    // Bus decode; everything is qualified by the block select.
    assign w_sel      = (bus.address[15:12] == BASE);
    assign w_wr       = w_sel && !bus.nWrite && bus.nRead;
    assign w_rd       = w_sel && !bus.nRead && bus.nWrite;
    assign w_both     = w_sel && !bus.nRead && !bus.nWrite;
    assign w_any      = w_sel && (!bus.nRead || !bus.nWrite);
    assign w_idle     = (r_state == S_IDLE);
    assign w_start    = (w_wr || w_rd) && (bus.address[3:0] == 4'd3) && w_idle;
    assign w_legal    = (bus.address[7:4] <= OP_SCI);
    assign w_start_ok = w_start && w_legal;
    assign w_err_set  = w_both || (w_any && (r_state == S_RUN)) || (w_start && !w_legal);
    assign w_rd_ok    = w_rd && (bus.address[3:0] == 4'd2) && (r_state != S_RUN);
    assign w_unused   = ^bus.address[11:8];

    // Element datapath: current element operands and multiply-accumulate step.
    assign w_a   = r_src1[f_idx(r_row, r_col)];
    assign w_b   = r_src2[f_idx(r_row, r_col)];
    assign w_mac = r_acc + r_src1[f_idx(r_row, r_k)] * r_src2[f_idx(r_k, r_col)];

    // Value written to result[row][col] this cycle.
    always_comb begin
        w_elem = '0;
        case (r_op)
            OP_MUL:  w_elem = w_mac;
            OP_ADD:  w_elem = w_a + w_b;
            OP_SUB:  w_elem = w_a - w_b;
            OP_TRN:  w_elem = r_src1[f_idx(r_col, r_row)];
            OP_SCL:  w_elem = w_a * r_src2[0];
            OP_SCI:  w_elem = w_a * r_scalar;
            default: w_elem = '0;
        endcase
    end

    assign w_elem_wr = (r_state == S_RUN) && ((r_op != OP_MUL) || (r_k == LAST));
    assign w_last    = w_elem_wr && (r_row == LAST) && (r_col == LAST);

    // Pack the result array onto the bus layout.
    always_comb begin
        w_res_packed = '0;
        for (int i = 0; i < int'(NE); i++) begin
            w_res_packed[i*DATA_W +: DATA_W] = r_res[i];
        end
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)     w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Status flags: busy/done follow the next state, err is sticky until a good start.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_RUN);
            r_done <= (w_state_nxt == S_DONE);
            if (w_start_ok) begin
                r_err <= 1'b0;
            end else if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Operand loads, command latch and read-data register.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < int'(NE); i++) begin
                r_src1[i] <= '0;
                r_src2[i] <= '0;
            end
            r_scalar <= '0;
            r_op     <= '0;
            r_mdo    <= '0;
        end else begin
            if (w_wr && w_idle && (bus.address[3:0] == 4'd0)) begin
                for (int i = 0; i < int'(NE); i++) r_src1[i] <= bus.ExeDataOut[i*DATA_W +: DATA_W];
            end
            if (w_wr && w_idle && (bus.address[3:0] == 4'd1)) begin
                for (int i = 0; i < int'(NE); i++) r_src2[i] <= bus.ExeDataOut[i*DATA_W +: DATA_W];
            end
            if (w_start_ok) begin
                r_op <= bus.address[7:4];
                if (w_wr) r_scalar <= bus.ExeDataOut[DATA_W-1:0];
            end
            if (w_rd_ok) begin
                r_mdo <= w_res_packed;
            end
        end
    end

    // Element sequencing: row/col/k counters, accumulator and result writes.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_row <= '0;
            r_col <= '0;
            r_k   <= '0;
            r_acc <= '0;
            for (int i = 0; i < int'(NE); i++) r_res[i] <= '0;
        end else if (w_start_ok) begin
            r_row <= '0;
            r_col <= '0;
            r_k   <= '0;
            r_acc <= '0;
        end else if (r_state == S_RUN) begin
            if (w_elem_wr) begin
                r_res[f_idx(r_row, r_col)] <= w_elem;
                r_acc <= '0;
                r_k   <= '0;
                if (r_col == LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == LAST) ? '0 : r_row + CW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end else begin
                r_acc <= w_mac;
                r_k   <= r_k + CW'(1);
            end
        end
    end

    assign bus.MatrixDataOut = r_mdo;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.err           = r_err;
endmodule

// File: tb/tb_matrix_alu_seq.sv
// Directed self-checking bench for matrix_alu_seq (DIM=4, DATA_W=16).
module tb_matrix_alu_seq;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DIM    = 4;
    localparam int unsigned NE     = DIM * DIM;
    localparam int unsigned MW     = NE * DATA_W;

    logic Clk;
    logic nReset;
    int   errors;
    int   checks;

    matrix_alu_seq_if #(.MW(MW)) bus ();

    matrix_alu_seq #(
        .DATA_W (DATA_W),
        .DIM    (DIM),
        .BASE   (4'h2)
    ) u_dut (
        .Clk    (Clk),
        .nReset (nReset),
        .bus    (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic bus_idle();
        bus.address    = 16'h0000;
        bus.nRead      = 1'b1;
        bus.nWrite     = 1'b1;
        bus.ExeDataOut = '0;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [MW-1:0] d);
        @(negedge Clk);
        bus.address    = a;
        bus.ExeDataOut = d;
        bus.nWrite     = 1'b0;
        bus.nRead      = 1'b1;
        @(negedge Clk);
        bus_idle();
    endtask

    task automatic bus_rd(input logic [15:0] a);
        @(negedge Clk);
        bus.address = a;
        bus.nRead   = 1'b0;
        bus.nWrite  = 1'b1;
        @(negedge Clk);
        bus_idle();
    endtask

    // Returns one half-cycle after the start edge.
    task automatic start_cmd(input logic [3:0] op, input logic use_wr, input logic [15:0] scalar);
        logic [15:0] a;
        a = {4'h2, 4'h0, op, 4'h3};
        @(negedge Clk);
        bus.address = a;
        if (use_wr) begin
            bus.nWrite     = 1'b0;
            bus.ExeDataOut = MW'(scalar);
        end else begin
            bus.nRead = 1'b0;
        end
        @(negedge Clk);
        bus_idle();
    endtask

    // Counts negedges from the one just after the start edge (=1) until done is seen.
    task automatic wait_done(input int limit, output int cyc, output int bcnt);
        cyc  = 1;
        bcnt = 0;
        while (!bus.done && cyc <= limit) begin
            if (bus.busy) bcnt++;
            @(negedge Clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        bus_idle();
        repeat (3) @(negedge Clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
        checks++; if (bus.MatrixDataOut !== '0) begin errors++; $display("FAIL reset_mdo: got %h want 0", bus.MatrixDataOut); end
        nReset = 1'b1;
        bus_rd(16'h2002);
        checks++; if (bus.MatrixDataOut !== '0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.MatrixDataOut); end
    endtask

    task automatic test_add();
        logic [MW-1:0] s1, s2, exp;
        int cyc, bcnt;
        for (int i = 0; i < int'(NE); i++) begin
            s1[i*DATA_W +: DATA_W]  = 16'(i + 1);
            s2[i*DATA_W +: DATA_W]  = 16'h0010;
            exp[i*DATA_W +: DATA_W] = 16'(i + 16'h11);
        end
        bus_wr(16'h2000, s1);
        bus_wr(16'h2001, s2);
        start_cmd(4'd1, 1'b0, 16'h0);
        wait_done(200, cyc, bcnt);
        checks++; if (cyc !== 17) begin errors++; $display("FAIL add_latency: got %0d want 17", cyc); end
        checks++; if (bcnt !== 16) begin errors++; $display("FAIL add_busy_cycles: got %0d want 16", bcnt); end
        @(negedge Clk);
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got done=%b busy=%b want 0 0", bus.done, bus.busy); end
        bus_rd(16'h2002);
        checks++; if (bus.MatrixDataOut !== exp) begin errors++; $display("FAIL add_result: got %h want %h", bus.MatrixDataOut, exp); end
    endtask

    task automatic test_multiply();
        logic [MW-1:0] s1, s2;
        int cyc, bcnt;
        for (int r = 0; r < int'(DIM); r++) begin
            for (int c = 0; c < int'(DIM); c++) begin
                s1[(r*DIM+c)*DATA_W +: DATA_W] = (r == c) ? 16'h0001 : 16'h0000;
                s2[(r*DIM+c)*DATA_W +: DATA_W] = 16'(r*DIM + c);
            end
        end
        bus_wr(16'h2000, s1);
        bus_wr(16'h2001, s2);
        start_cmd(4'd0, 1'b0, 16'h0);
        wait_done(200, cyc, bcnt);
        checks++; if (cyc !== 65) begin errors++; $display("FAIL mul_latency: got %0d want 65", cyc); end
        checks++; if (bcnt !== 64) begin errors++; $display("FAIL mul_busy_cycles: got %0d want 64", bcnt); end
        // read issued in the DONE cycle
        bus.address = 16'h2002;
        bus.nRead   = 1'b0;
        @(negedge Clk);
        bus_idle();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse: got %b want 0", bus.done); end
        checks++; if (bus.MatrixDataOut !== s2) begin errors++; $display("FAIL mul_result: got %h want %h", bus.MatrixDataOut, s2); end
    endtask

    task automatic test_scale_ops();
        logic [MW-1:0] s1, s2, exp;
        int cyc, bcnt;
        // SCALEIMM wrap: 0x8001 * 2 = 0x10002 -> 0x0002
        for (int i = 0; i < int'(NE); i++) begin
            s1[i*DATA_W +: DATA_W]  = 16'h8001;
            exp[i*DATA_W +: DATA_W] = 16'h0002;
        end
        bus_wr(16'h2000, s1);
        start_cmd(4'd5, 1'b1, 16'h0002);
        wait_done(200, cyc, bcnt);
        bus_rd(16'h2002);
        checks++; if (bus.MatrixDataOut !== exp) begin errors++; $display("FAIL scaleimm_result: got %h want %h", bus.MatrixDataOut, exp); end
        // SCALE by src2[0][0] = 3
        for (int i = 0; i < int'(NE); i++) begin
            s1[i*DATA_W +: DATA_W]  = 16'(i);
            s2[i*DATA_W +: DATA_W]  = (i == 0) ? 16'h0003 : 16'h0007;
            exp[i*DATA_W +: DATA_W] = 16'(3 * i);
        end
        bus_wr(16'h2000, s1);
        bus_wr(16'h2001, s2);
        start_cmd(4'd4, 1'b0, 16'h0);
        wait_done(200, cyc, bcnt);
        checks++; if (cyc !== 17) begin errors++; $display("FAIL scale_latency: got %0d want 17", cyc); end
        bus_rd(16'h2002);
        checks++; if (bus.MatrixDataOut !== exp) begin errors++; $display("FAIL scale_result: got %h want %h", bus.MatrixDataOut, exp); end
    endtask

    task automatic test_subtract();
        logic [MW-1:0] s1, s2, exp;
        int cyc, bcnt;
        for (int i = 0; i < int'(NE); i++) begin
            s1[i*DATA_W +: DATA_W]  = 16'h0000;
            s2[i*DATA_W +: DATA_W]  = 16'h0001;
            exp[i*DATA_W +: DATA_W] = 16'hFFFF;
        end
        bus_wr(16'h2000, s1);
        bus_wr(16'h2001, s2);
        start_cmd(4'd2, 1'b0, 16'h0);
        wait_done(200, cyc, bcnt);
        bus_rd(16'h2002);
        checks++; if (bus.MatrixDataOut !== exp) begin errors++; $display("FAIL sub_result: got %h want %h", bus.MatrixDataOut, exp); end
    endtask

    task automatic test_transpose();
        logic [MW-1:0] s1, exp;
        int cyc, bcnt;
        for (int r = 0; r < int'(DIM); r++) begin
            for (int c = 0; c < int'(DIM); c++) begin
                s1[(r*DIM+c)*DATA_W +: DATA_W]  = 16'(r*16 + c);
                exp[(r*DIM+c)*DATA_W +: DATA_W] = 16'(c*16 + r);
            end
        end
        bus_wr(16'h2000, s1);
        start_cmd(4'd3, 1'b0, 16'h0);
        wait_done(200, cyc, bcnt);
        bus_rd(16'h2002);
        checks++; if (bus.MatrixDataOut !== exp) begin errors++; $display("FAIL trn_result: got %h want %h", bus.MatrixDataOut, exp); end
    endtask

    task automatic test_errors();
        logic [MW-1:0] s1, zero, ones;
        int cyc, bcnt;
        zero = '0;
        ones = '1;
        for (int i = 0; i < int'(NE); i++) s1[i*DATA_W +: DATA_W] = 16'(16'h0100 + i);
        bus_wr(16'h2000, s1);
        bus_wr(16'h2001, zero);
        start_cmd(4'd1, 1'b0, 16'h0);
        bus_wr(16'h2000, ones);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL busy_write_err: got %b want 1", bus.err); end
        wait_done(200, cyc, bcnt);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", bus.err); end
        start_cmd(4'd1, 1'b0, 16'h0);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL err_clear_start: got %b want 0", bus.err); end
        wait_done(200, cyc, bcnt);
        bus_rd(16'h2002);
        checks++; if (bus.MatrixDataOut !== s1) begin errors++; $display("FAIL busy_write_ignored: got %h want %h", bus.MatrixDataOut, s1); end
        // illegal opcode
        start_cmd(4'd7, 1'b0, 16'h0);
        checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL illegal_op: got err=%b busy=%b want 1 0", bus.err, bus.busy); end
        start_cmd(4'd3, 1'b0, 16'h0);
        checks++; if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL valid_after_illegal: got err=%b busy=%b want 0 1", bus.err, bus.busy); end
        wait_done(200, cyc, bcnt);
        // both strobes low: error, no write
        @(negedge Clk);
        bus.address    = 16'h2000;
        bus.ExeDataOut = ones;
        bus.nRead      = 1'b0;
        bus.nWrite     = 1'b0;
        @(negedge Clk);
        bus_idle();
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL both_strobes_err: got %b want 1", bus.err); end
        // foreign block select: ignored
        bus_wr(16'h3000, ones);
        start_cmd(4'd1, 1'b0, 16'h0);
        wait_done(200, cyc, bcnt);
        bus_rd(16'h2002);
        checks++; if (bus.MatrixDataOut !== s1) begin errors++; $display("FAIL select_ignored: got %h want %h", bus.MatrixDataOut, s1); end
    endtask

    task automatic test_reset_midop();
        logic [MW-1:0] s1, s2, exp;
        int cyc, bcnt;
        start_cmd(4'd0, 1'b0, 16'h0);
        repeat (29) @(negedge Clk);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midop_busy: got %b want 1", bus.busy); end
        nReset = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL midop_flags: got busy=%b done=%b err=%b want 0 0 0", bus.busy, bus.done, bus.err); end
        checks++; if (bus.MatrixDataOut !== '0) begin errors++; $display("FAIL midop_mdo: got %h want 0", bus.MatrixDataOut); end
        @(negedge Clk);
        nReset = 1'b1;
        bus_rd(16'h2002);
        checks++; if (bus.MatrixDataOut !== '0) begin errors++; $display("FAIL midop_result: got %h want 0", bus.MatrixDataOut); end
        for (int i = 0; i < int'(NE); i++) begin
            s1[i*DATA_W +: DATA_W]  = 16'(i + 1);
            s2[i*DATA_W +: DATA_W]  = 16'h0010;
            exp[i*DATA_W +: DATA_W] = 16'(i + 16'h11);
        end
        bus_wr(16'h2000, s1);
        bus_wr(16'h2001, s2);
        start_cmd(4'd1, 1'b0, 16'h0);
        wait_done(200, cyc, bcnt);
        checks++; if (cyc !== 17) begin errors++; $display("FAIL post_reset_latency: got %0d want 17", cyc); end
        bus_rd(16'h2002);
        checks++; if (bus.MatrixDataOut !== exp) begin errors++; $display("FAIL post_reset_add: got %h want %h", bus.MatrixDataOut, exp); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        nReset = 1'b0;
        bus_idle();
        test_reset();
        test_add();
        test_multiply();
        test_scale_ops();
        test_subtract();
        test_transpose();
        test_errors();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
